// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer: FSM states,
// instruction-class encodings and ALU control codes.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_RTYPE  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_LDST   = 2'b10;
  localparam logic [1:0] OP_MULTI  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response handshake bundle between a requester and the ALU control sequencer.
interface alu_ctrl_seq_if #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [OPC_W-1:0] opcode;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] alu_cnt;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, opcode, out_ready,
    input  in_ready, out_valid, alu_cnt, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, opcode, out_ready,
    output in_ready, out_valid, alu_cnt, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of (alu_op, opcode) into ALU code, multi-cycle flag
// and illegal flag; unmatched combinations fall back to ADD as single-cycle.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int CNT_W = 4
) (
  input  logic [1:0]       alu_op,
  input  logic [OPC_W-1:0] opcode,
  output logic [CNT_W-1:0] code,
  output logic             multi,
  output logic             illegal
);

  logic [31:0] w_opc;
  logic [3:0]  w_code;

  assign w_opc = 32'(opcode);

  always_comb begin
    w_code  = ALU_ADD;
    multi   = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      OP_LDST:   w_code = ALU_ADD;
      OP_BRANCH: w_code = ALU_SUB;
      OP_RTYPE: begin
        // R-type function opcodes 2..9 map linearly onto codes 0..7
        if (w_opc >= 32'd2 && w_opc <= 32'd9) begin
          w_code = 4'(w_opc - 32'd2);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_MULTI: begin
        if (w_opc == 32'd0) begin
          w_code = ALU_MUL;
          multi  = 1'b1;
        end else if (w_opc == 32'd1) begin
          w_code = ALU_DIV;
          multi  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign code = CNT_W'(w_code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decode of each accepted request and presents it
// with valid/ready; MUL/DIV wait MC_LAT cycles, back-to-back single-cycle ops run at 1/cycle.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int CNT_W  = 4,
  parameter int MC_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_seq_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [CNT_W-1:0] r_alu_cnt;
  logic             r_illegal;

  logic [CNT_W-1:0] w_code;
  logic             w_multi;
  logic             w_illegal;
  logic             w_in_ready;
  logic             w_accept;

  alu_ctrl_decode #(
    .OPC_W (OPC_W),
    .CNT_W (CNT_W)
  ) u_decode (
    .alu_op  (bus.alu_op),
    .opcode  (bus.opcode),
    .code    (w_code),
    .multi   (w_multi),
    .illegal (w_illegal)
  );

  // OUT can take a new request in the same cycle its result is consumed
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_multi ? S_WAIT : S_OUT;
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (w_accept) w_state_nxt = w_multi ? S_WAIT : S_OUT;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_alu_cnt <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_cnt <= w_code;
        r_illegal <= w_illegal;
        r_cnt     <= w_multi ? 8'(MC_LAT - 1) : 8'd0;
      end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.alu_cnt   = r_alu_cnt;
  assign bus.illegal   = r_illegal;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001: Parameter OPC_W, default 4: width of the opcode field.
REQ-002: Parameter CNT_W, default 4: width of alu_cnt; SHALL be at least 4.
REQ-003: Parameter MC_LAT, default 4, legal range 1..255: wait cycles for multi-cycle ops.
REQ-004: Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005: Port rst, input, 1: reset, synchronous and active-high.
REQ-006: Port in_valid, input, 1: the alu_op/opcode request is valid.
REQ-007: Port in_ready, output, 1: the block can accept a request.
REQ-008: Port alu_op, input, 2: instruction class (00 R-type, 01 branch, 10 load/store, 11 multi-cycle).
REQ-009: Port opcode, input, OPC_W: function opcode.
REQ-010: Port out_valid, output, 1: alu_cnt and illegal are valid.
REQ-011: Port out_ready, input, 1: the consumer accepts the output.
REQ-012: Port alu_cnt, output, CNT_W: registered ALU control code.
REQ-013: Port illegal, output, 1: the accepted request had no legal decode.
REQ-014: Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015: The block SHALL accept a request on any cycle with in_valid && in_ready.
REQ-016: Decode for alu_op=10 SHALL be code 0 (ADD); opcode is don't-care.
REQ-017: Decode for alu_op=01 SHALL be code 1 (SUB); opcode is don't-care.
REQ-018: Decode for alu_op=00 SHALL map opcode 2..9 to codes 0..7 respectively.
REQ-019: Decode for alu_op=11 SHALL map opcode 0 to code 8 (MUL) and opcode 1 to code 9 (DIV); both are multi-cycle.
REQ-020: Any other combination SHALL decode to code 0 with illegal=1; it is treated as single-cycle.
REQ-021: The FSM SHALL have three states: IDLE, WAIT, OUT.
REQ-022: IDLE, on accept of a single-cycle op: the decode is registered and the next state is OUT; out_valid is asserted in the cycle after accept.
REQ-023: IDLE, on accept of a multi-cycle op: the decode is registered, the counter loads MC_LAT-1, and the next state is WAIT.
REQ-024: WAIT: the counter decrements each cycle; on the cycle it reads 0 the next state is OUT; out_valid rises MC_LAT+1 cycles after accept.
REQ-025: OUT: out_valid=1, and alu_cnt/illegal SHALL hold stable until out_ready=1.
REQ-026: OUT with out_ready=1 and no new accept: the next state is IDLE.
REQ-027: in_ready SHALL be (state==IDLE) || (state==OUT && out_ready), computed combinationally.
REQ-028: OUT with out_ready=1 and a simultaneous accept: the new request is decoded as in IDLE, giving back-to-back single-cycle throughput of 1 per cycle.
REQ-029: In WAIT, in_ready=0; input changes SHALL be ignored.
REQ-030: The input is not sampled unless in_valid && in_ready.
REQ-031: out_valid SHALL NOT depend combinationally on any input.

Reset
REQ-032: While rst=1 at a clock edge, the next state SHALL be IDLE, the counter 0, alu_cnt 0, illegal 0, and out_valid 0.
REQ-033: rst SHALL override any operation mid-flight (WAIT or OUT); the pending result is discarded with no out_valid pulse.
REQ-034: in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035: Package alu_ctrl_pkg SHALL hold the state enum, the alu_op class constants, and the ALU code constants (ADD=0 .. DIV=9).
REQ-036: Pure decode SHALL sit in the combinational sub-module alu_ctrl_decode (inputs alu_op and opcode; outputs code, multi, illegal); FSM, counter and registers stay in alu_ctrl_seq.

Verification
REQ-037: Reset mid-op: MUL accepted, then rst in the 2nd WAIT cycle -> no out_valid, then IDLE with in_ready=1.
REQ-038: alu_op=00 with opcode 2..9 in turn, out_ready=1 throughout -> alu_cnt 0..7 on consecutive cycles, out_valid stays 1, illegal=0.
REQ-039: alu_op=11, opcode=1, MC_LAT=4 -> busy=1, in_ready=0 for 4 cycles; out_valid rises 5 cycles after accept with alu_cnt=9.
REQ-040: alu_op=00, opcode=15 -> alu_cnt=0, illegal=1, one cycle latency.
REQ-041: Backpressure: out_ready=0 for 3 cycles after an ADD result -> alu_cnt held at 0, in_ready=0, no second accept; out_ready=1 releases it.
REQ-042: alu_op=10 and alu_op=01 with random opcodes -> alu_cnt 0 and 1 respectively.
